// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryption core: one full round per clock, with the
// whole key schedule expanded combinationally and captured when a block is accepted.

package aes_pkg;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of the 128-bit state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
        return res;
    endfunction

endpackage

module aes_key_expansion #(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic [32*NK-1:0]      key,
    output logic [128*(NR+1)-1:0] round_keys
);
    import aes_pkg::*;

    // Round key r occupies bits [128r +: 128].
    function automatic logic [128*(NR+1)-1:0] expand(input logic [32*NK-1:0] k);
        logic [31:0]             w [4*(NR+1)];
        logic [31:0]             temp;
        logic [7:0]              rcon;
        logic [128*(NR+1)-1:0]   rks;
        rcon = 8'h01;
        temp = '0;
        rks  = '0;
        for (int i = 0; i < 4*(NR+1); i++) begin
            if (i < NK) begin
                w[i] = k[32*(NK-i)-1 -: 32];
            end else begin
                temp = w[i-1];
                if (i % NK == 0) begin
                    temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                    rcon = xtime(rcon);
                end else if (NK == 8 && i % NK == 4) begin
                    temp = sub_word(temp);
                end
                w[i] = w[i-NK] ^ temp;
            end
        end
        for (int r = 0; r <= NR; r++)
            rks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rks;
    endfunction

    assign round_keys = expand(key);

endmodule

module aes_iter_core #(
    parameter  int NK = 4,
    localparam int NR = NK + 6,
    localparam int KW = 32 * NK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [127:0]  i_plaintext,
    input  logic [KW-1:0] i_key,
    input  logic          i_abort,
    output logic [127:0]  o_ciphertext,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_busy,
    output logic [3:0]    o_round
);
    import aes_pkg::*;

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_iter_core: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, INIT, ROUND, HOLD} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t                state_q, state_d;
    logic [127:0]          data_q;
    logic [127:0]          rk_q [NR+1];
    logic [3:0]            cnt_q;
    logic [128*(NR+1)-1:0] rk_exp;
    logic [127:0]          round_out;

    aes_key_expansion #(.NK(NK), .NR(NR)) u_key_exp (
        .key        (i_key),
        .round_keys (rk_exp)
    );

    assign round_out = aes_round(data_q, rk_q[cnt_q], cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_busy       = 1'b0;
        o_round      = 4'd0;
        o_ciphertext = '0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_d = INIT;
            end
            INIT: begin
                o_busy  = 1'b1;
                state_d = i_abort ? IDLE : ROUND;
            end
            ROUND: begin
                o_busy  = 1'b1;
                o_round = cnt_q;
                if (i_abort)            state_d = IDLE;
                else if (cnt_q == LAST) state_d = HOLD;
            end
            HOLD: begin
                o_valid      = 1'b1;
                o_ciphertext = data_q;
                // Abort together with i_ready still counts as a completed transfer.
                if (i_abort || i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            for (int r = 0; r <= NR; r++) rk_q[r] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_q <= i_plaintext;
                        for (int r = 0; r <= NR; r++) rk_q[r] <= rk_exp[128*r +: 128];
                    end
                end
                INIT: begin
                    if (!i_abort) begin
                        data_q <= data_q ^ rk_q[0];
                        cnt_q  <= 4'd1;
                    end
                end
                ROUND: begin
                    if (!i_abort) data_q <= round_out;
                    if (i_abort || cnt_q == LAST) cnt_q <= '0;
                    else                          cnt_q <= cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: FIPS-197 vectors for NK=4/6/8 plus random blocks
// checked against a byte-level AES model whose S-box is derived from GF(2^8) inversion.

module tb_aes_iter_core;

    localparam logic [127:0] KAT_PT4 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KAT_K4  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_CT4 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KAT_PTW = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KAT_K6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] KAT_CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KAT_K8  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic         v4, or4, ab4, ir4, ov4, busy4;
    logic [127:0] pt4, key4, ct4;
    logic [3:0]   rnd4;

    logic         v6, or6, ov6, busy6, v8, or8, ov8, busy8, ab_w, ir_w;
    logic [127:0] p6, ct6, p8, ct8;
    logic [191:0] k6;
    logic [255:0] k8;
    logic [3:0]   rnd6, rnd8;

    aes_iter_core #(.NK(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(v4), .o_ready(or4), .i_plaintext(pt4), .i_key(key4),
        .i_abort(ab4), .o_ciphertext(ct4), .o_valid(ov4), .i_ready(ir4), .o_busy(busy4),
        .o_round(rnd4));

    aes_iter_core #(.NK(6)) dut6 (
        .clk(clk), .rst(rst), .i_valid(v6), .o_ready(or6), .i_plaintext(p6), .i_key(k6),
        .i_abort(ab_w), .o_ciphertext(ct6), .o_valid(ov6), .i_ready(ir_w), .o_busy(busy6),
        .o_round(rnd6));

    aes_iter_core #(.NK(8)) dut8 (
        .clk(clk), .rst(rst), .i_valid(v8), .o_ready(or8), .i_plaintext(p8), .i_key(k8),
        .i_abort(ab_w), .o_ciphertext(ct8), .o_valid(ov8), .i_ready(ir_w), .o_busy(busy8),
        .o_round(rnd8));

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // key is right-aligned: its nk words occupy bits [32*nk-1:0].
    function automatic logic [127:0] ref_aes(input logic [255:0] key, input int nk,
                                             input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[32*(nk-i)-1 -: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = {tmp[23:0], tmp[31:24]};
                    tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]],
                           sbox_m[tmp[7:0]]} ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]],
                           sbox_m[tmp[7:0]]};
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int i = 0; i < 16; i++) t[i] = s[(i + 4*(i%4)) % 16];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = (r == nr) ? t[4*c+j] :
                               gmul(8'h02, t[4*c+j]) ^ gmul(8'h03, t[4*c+(j+1)%4]) ^
                               t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Called at a negedge with dut4 idle; returns at the negedge after the accept edge.
    task automatic accept4(input logic [127:0] pt, input logic [127:0] key);
        v4 = 1'b1;
        pt4 = pt;
        key4 = key;
        @(negedge clk);
        v4 = 1'b0;
        pt4 = rand128();
        key4 = rand128();
    endtask

    // Edges are counted with the accept edge as edge 1; inputs are scrambled while busy.
    task automatic wait4(output int lat);
        lat = 1;
        while (!ov4 && lat < 40) begin
            v4 = 1'($urandom);
            pt4 = rand128();
            key4 = rand128();
            @(negedge clk);
            lat++;
        end
        v4 = 1'b0;
    endtask

    task automatic go_wide(input int nk, input logic [255:0] key, input logic [127:0] pt,
                           output int lat, output logic [127:0] ct);
        if (nk == 6) begin v6 = 1'b1; k6 = key[191:0]; p6 = pt; end
        else         begin v8 = 1'b1; k8 = key;        p8 = pt; end
        @(negedge clk);
        v6 = 1'b0; v8 = 1'b0;
        k6 = ~k6;  k8 = ~k8;  p6 = ~p6;  p8 = ~p8;
        lat = 1;
        while (((nk == 6) ? !ov6 : !ov8) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ct = (nk == 6) ? ct6 : ct8;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        v4 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({or4, ov4, busy4, rnd4, ct4} !== {1'b1, 1'b0, 1'b0, 4'd0, 128'd0}) begin
            failures++;
            $display("FAIL reset_nk4 got rdy=%b val=%b busy=%b rnd=%0d ct=%h exp 1 0 0 0 0",
                     or4, ov4, busy4, rnd4, ct4);
        end
        checks++;
        if ({or6, ov6, busy6, rnd6, ct6, or8, ov8, busy8, rnd8, ct8} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 128'd0, 1'b1, 1'b0, 1'b0, 4'd0, 128'd0}) begin
            failures++;
            $display("FAIL reset_wide got r6=%b v6=%b b6=%b r8=%b v8=%b b8=%b exp 1 0 0 1 0 0",
                     or6, ov6, busy6, or8, ov8, busy8);
        end
        v4 = 1'b0;
    endtask

    task automatic test_first_accept_kat();
        int lat;
        @(negedge clk);
        pt4 = KAT_PT4;
        key4 = KAT_K4;
        v4 = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        pt4 = rand128();
        key4 = rand128();
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("FAIL first_accept busy=%b exp=1", busy4);
        end
        wait4(lat);
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL kat128_latency got=%0d exp=12", lat);
        end
        checks++;
        if (ct4 !== KAT_CT4) begin
            failures++;
            $display("FAIL kat128_ct got=%h exp=%h", ct4, KAT_CT4);
        end
        ir4 = 1'b1;
        @(negedge clk);
        ir4 = 1'b0;
        checks++;
        if ({or4, ov4} !== 2'b10) begin
            failures++;
            $display("FAIL ready_after_transfer got rdy=%b val=%b exp 1 0", or4, ov4);
        end
    endtask

    task automatic test_kat_wide();
        int lat;
        logic [127:0] ct, pt;
        logic [255:0] key;
        go_wide(6, {64'h0, KAT_K6}, KAT_PTW, lat, ct);
        checks++;
        if (lat !== 14 || ct !== KAT_CT6) begin
            failures++;
            $display("FAIL kat192 got lat=%0d ct=%h exp lat=14 ct=%h", lat, ct, KAT_CT6);
        end
        go_wide(8, KAT_K8, KAT_PTW, lat, ct);
        checks++;
        if (lat !== 16 || ct !== KAT_CT8) begin
            failures++;
            $display("FAIL kat256 got lat=%0d ct=%h exp lat=16 ct=%h", lat, ct, KAT_CT8);
        end
        for (int n = 0; n < 6; n++) begin
            pt = rand128();
            key = {rand128(), rand128()};
            if (n % 2 == 0) key[255:192] = '0;
            go_wide((n % 2 == 0) ? 6 : 8, key, pt, lat, ct);
            checks++;
            if (ct !== ref_aes(key, (n % 2 == 0) ? 6 : 8, pt)) begin
                failures++;
                $display("FAIL random_wide nk=%0d got=%h exp=%h", (n % 2 == 0) ? 6 : 8, ct,
                         ref_aes(key, (n % 2 == 0) ? 6 : 8, pt));
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, key, exp_ct, held;
        int lat, stall, exp_round;
        bit trace_ok, stable;
        for (int n = 0; n < 8; n++) begin
            pt = rand128();
            key = rand128();
            exp_ct = ref_aes({128'h0, key}, 4, pt);
            accept4(pt, key);
            lat = 1;
            trace_ok = 1'b1;
            while (!ov4 && lat < 40) begin
                exp_round = (lat >= 2 && lat <= 11) ? lat - 1 : 0;
                if (rnd4 !== 4'(exp_round) || busy4 !== (lat <= 11) || or4 !== 1'b0)
                    trace_ok = 1'b0;
                v4 = 1'($urandom);
                pt4 = rand128();
                key4 = rand128();
                @(negedge clk);
                lat++;
            end
            v4 = 1'b0;
            checks++;
            if (!trace_ok) begin
                failures++;
                $display("FAIL round_trace block=%0d o_round/o_busy/o_ready sequence wrong", n);
            end
            checks++;
            if (lat !== 12 || ct4 !== exp_ct) begin
                failures++;
                $display("FAIL random128 block=%0d got lat=%0d ct=%h exp lat=12 ct=%h",
                         n, lat, ct4, exp_ct);
            end
            held = ct4;
            stall = $urandom_range(0, 3);
            stable = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                if (ct4 !== held || ov4 !== 1'b1) stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                failures++;
                $display("FAIL random_hold block=%0d ct=%h val=%b exp ct=%h val=1",
                         n, ct4, ov4, held);
            end
            ir4 = 1'b1;
            @(negedge clk);
            ir4 = 1'b0;
        end
    endtask

    task automatic test_hold_stall();
        int lat;
        logic [127:0] pt, key;
        accept4(KAT_PT4, KAT_K4);
        wait4(lat);
        for (int i = 0; i < 5; i++) begin
            v4 = ~v4;
            pt4 = rand128();
            @(negedge clk);
            checks++;
            if (ct4 !== KAT_CT4 || ov4 !== 1'b1 || or4 !== 1'b0) begin
                failures++;
                $display("FAIL hold_stall cycle=%0d got ct=%h val=%b rdy=%b exp ct=%h 1 0",
                         i, ct4, ov4, or4, KAT_CT4);
            end
        end
        v4 = 1'b0;
        ir4 = 1'b1;
        @(negedge clk);
        ir4 = 1'b0;
        checks++;
        if ({or4, ov4} !== 2'b10) begin
            failures++;
            $display("FAIL hold_release got rdy=%b val=%b exp 1 0", or4, ov4);
        end
        pt = rand128();
        key = rand128();
        accept4(pt, key);
        wait4(lat);
        checks++;
        if (ct4 !== ref_aes({128'h0, key}, 4, pt)) begin
            failures++;
            $display("FAIL back_to_back got=%h exp=%h", ct4, ref_aes({128'h0, key}, 4, pt));
        end
        ir4 = 1'b1;
        @(negedge clk);
        ir4 = 1'b0;
    endtask

    task automatic test_abort();
        int n, lat;
        bit quiet;
        accept4(rand128(), rand128());
        n = 0;
        while (rnd4 !== 4'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rnd4 !== 4'd5) begin
            failures++;
            $display("FAIL abort_reach_round5 got round=%0d exp=5", rnd4);
        end
        ab4 = 1'b1;
        @(negedge clk);
        ab4 = 1'b0;
        checks++;
        if ({or4, ov4, busy4, rnd4} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL abort_to_idle got rdy=%b val=%b busy=%b rnd=%0d exp 1 0 0 0",
                     or4, ov4, busy4, rnd4);
        end
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ov4 !== 1'b0 || busy4 !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL abort_no_valid activity seen after abort, exp none");
        end
        ab4 = 1'b1;
        v4 = 1'b1;
        pt4 = KAT_PT4;
        key4 = KAT_K4;
        @(negedge clk);
        ab4 = 1'b0;
        v4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("FAIL abort_with_accept busy=%b exp=1", busy4);
        end
        wait4(lat);
        checks++;
        if (ct4 !== KAT_CT4) begin
            failures++;
            $display("FAIL abort_then_kat got=%h exp=%h", ct4, KAT_CT4);
        end
        ab4 = 1'b1;
        ir4 = 1'b1;
        @(negedge clk);
        ab4 = 1'b0;
        ir4 = 1'b0;
        checks++;
        if ({or4, ov4} !== 2'b10) begin
            failures++;
            $display("FAIL abort_with_ready got rdy=%b val=%b exp 1 0", or4, ov4);
        end
        accept4(rand128(), rand128());
        wait4(lat);
        ab4 = 1'b1;
        @(negedge clk);
        ab4 = 1'b0;
        checks++;
        if ({or4, ov4, busy4} !== 3'b100) begin
            failures++;
            $display("FAIL abort_in_hold got rdy=%b val=%b busy=%b exp 1 0 0", or4, ov4, busy4);
        end
    endtask

    task automatic test_reset_mid();
        int n, lat;
        bit quiet;
        logic [127:0] pt, key;
        accept4(rand128(), rand128());
        n = 0;
        while (rnd4 !== 4'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({or4, ov4, busy4, rnd4, ct4} !== {1'b1, 1'b0, 1'b0, 4'd0, 128'd0}) begin
            failures++;
            $display("FAIL reset_mid got rdy=%b val=%b busy=%b rnd=%0d ct=%h exp 1 0 0 0 0",
                     or4, ov4, busy4, rnd4, ct4);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ov4 !== 1'b0 || busy4 !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL reset_mid_no_valid activity seen after reset, exp none");
        end
        pt = rand128();
        key = rand128();
        accept4(pt, key);
        wait4(lat);
        checks++;
        if (lat !== 12 || ct4 !== ref_aes({128'h0, key}, 4, pt)) begin
            failures++;
            $display("FAIL after_reset_block got lat=%0d ct=%h exp lat=12 ct=%h",
                     lat, ct4, ref_aes({128'h0, key}, 4, pt));
        end
        ir4 = 1'b1;
        @(negedge clk);
        ir4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b0; ab4 = 1'b0; ir4 = 1'b0; pt4 = '0; key4 = '0;
        v6 = 1'b0; v8 = 1'b0; p6 = '0; p8 = '0; k6 = '0; k8 = '0;
        ab_w = 1'b0; ir_w = 1'b1;
        build_sbox();
        #12;
        test_reset();
        test_first_accept_kat();
        test_kat_wide();
        test_random();
        test_hold_stall();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
